mesm6_mem_arbiter: RTL

- Sits directly downstream of mesm6_core: terminates its instruction bus (ibus_*) and data bus (dbus_*).
- Serialises both buses onto one single-port main-memory request/acknowledge interface.
- Only one memory transaction is outstanding at a time. Read data is registered.
- Produces the done handshakes that release the core's microcode stall, plus a bus-timeout watchdog.

---
 rtl/mesm6_mem_pkg.sv | 26 ++
 rtl/mesm6_mem_arbiter_if.sv | 56 +++++
 rtl/mesm6_bus_watchdog.sv | 31 +++
 rtl/mesm6_mem_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mesm6_mem_pkg.sv
// Shared types and defaults for the mesm6 memory arbiter slice.
package mesm6_mem_pkg;

   localparam int unsigned ADDR_BITS_DEF = 15;
   localparam int unsigned DATA_BITS_DEF = 48;
   localparam int unsigned WDOG_BITS     = 16;

   // Arbiter sequencing: pick a port, run one memory access, one bookkeeping cycle.
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   // Which core bus owns the transaction in flight.
   typedef enum logic {
      PORT_I,
      PORT_D
   } port_e;

   // A data request is a read, a write, or both (both resolves to a write).
   function automatic logic dbus_active(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/mesm6_mem_arbiter_if.sv
// Core instruction/data buses plus the single-port memory interface, as seen
// by the arbiter (slave) and by the core/memory environment (master).
interface mesm6_mem_arbiter_if
   import mesm6_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
   parameter int unsigned DATA_BITS = DATA_BITS_DEF
);

   // Instruction bus
   logic                 ibus_fetch;
   logic [ADDR_BITS-1:0] ibus_addr;
   logic [DATA_BITS-1:0] ibus_input;
   logic                 ibus_done;

   // Data bus
   logic                 dbus_read;
   logic                 dbus_write;
   logic [ADDR_BITS-1:0] dbus_addr;
   logic [DATA_BITS-1:0] dbus_output;
   logic [DATA_BITS-1:0] dbus_input;
   logic                 dbus_done;

   // Main memory
   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [DATA_BITS-1:0] mem_wdata;
   logic [DATA_BITS-1:0] mem_rdata;
   logic                 mem_ack;

   // Watchdog report
   logic                 bus_error;
   logic [ADDR_BITS-1:0] err_addr;

   modport slave (
      input  ibus_fetch, ibus_addr,
      input  dbus_read, dbus_write, dbus_addr, dbus_output,
      input  mem_rdata, mem_ack,
      output ibus_input, ibus_done,
      output dbus_input, dbus_done,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output bus_error, err_addr
   );

   modport master (
      output ibus_fetch, ibus_addr,
      output dbus_read, dbus_write, dbus_addr, dbus_output,
      output mem_rdata, mem_ack,
      input  ibus_input, ibus_done,
      input  dbus_input, dbus_done,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  bus_error, err_addr
   );

endinterface

// File: rtl/mesm6_bus_watchdog.sv
// Wait-state counter for an outstanding memory request. Held at zero while
// idle, counts while running, saturates, and flags the cycle in which the
// request has waited TIMEOUT cycles without being acknowledged.
module mesm6_bus_watchdog
   import mesm6_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic expired
);

   localparam logic [WDOG_BITS-1:0] THRESH  = WDOG_BITS'(TIMEOUT - 1);
   localparam logic [WDOG_BITS-1:0] CNT_MAX = {WDOG_BITS{1'b1}};

   logic [WDOG_BITS-1:0] count;

   // Restart from zero whenever not running so each access begins at 0.
   always_ff @(posedge clk) begin
      if (reset || !run) begin
         count <= '0;
      end else if (count != CNT_MAX) begin
         count <= count + 1'b1;
      end
   end

   assign expired = run && (count == THRESH);

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// Serialises the mesm6 core's instruction and data buses onto one
// single-port memory. One transaction outstanding at a time; the data bus
// wins ties. Done flags are sticky until the core advances, so a core that
// issues both buses at once sees both dones high together.
module mesm6_mem_arbiter
   import mesm6_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
   parameter int unsigned DATA_BITS = DATA_BITS_DEF,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   mesm6_mem_arbiter_if.slave   bus
);

   state_e               state;
   port_e                sel;

   logic                 ibus_done_q;
   logic                 dbus_done_q;
   logic [DATA_BITS-1:0] ibus_input_q;
   logic [DATA_BITS-1:0] dbus_input_q;

   logic                 mem_req_q;
   logic                 mem_we_q;
   logic [ADDR_BITS-1:0] mem_addr_q;
   logic [DATA_BITS-1:0] mem_wdata_q;

   logic                 bus_error_q;
   logic [ADDR_BITS-1:0] err_addr_q;

   logic                 dbus_req;
   logic                 i_pend;
   logic                 d_pend;
   logic                 advance;
   logic                 still_req;
   logic                 wdog_expired;

   // Request decode and the core's advance condition.
   always_comb begin
      dbus_req  = dbus_active(bus.dbus_read, bus.dbus_write);
      i_pend    = bus.ibus_fetch & ~ibus_done_q;
      d_pend    = dbus_req & ~dbus_done_q;
      advance   = (ibus_done_q | dbus_done_q) &
                  (~bus.ibus_fetch | ibus_done_q) &
                  (~dbus_req | dbus_done_q);
      // A request withdrawn mid-access still completes on memory, silently.
      still_req = (sel == PORT_D) ? dbus_req : bus.ibus_fetch;
   end

   mesm6_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .run     (state == ACCESS),
      .expired (wdog_expired)
   );

   // Arbiter FSM with all bus outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         sel          <= PORT_I;
         ibus_done_q  <= 1'b0;
         dbus_done_q  <= 1'b0;
         ibus_input_q <= '0;
         dbus_input_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         bus_error_q  <= 1'b0;
         err_addr_q   <= '0;
      end else begin
         bus_error_q <= 1'b0;

         // Core consumed the dones this cycle; new requests appear next cycle.
         if (advance) begin
            ibus_done_q <= 1'b0;
            dbus_done_q <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (d_pend) begin
                  sel         <= PORT_D;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.dbus_write;
                  mem_addr_q  <= bus.dbus_addr;
                  mem_wdata_q <= bus.dbus_write ? bus.dbus_output : '0;
                  state       <= ACCESS;
               end else if (i_pend) begin
                  sel         <= PORT_I;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.ibus_addr;
                  mem_wdata_q <= '0;
                  state       <= ACCESS;
               end
            end

            ACCESS: begin
               // Ack is checked first so an ack on the threshold cycle is a
               // normal completion.
               if (bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (!mem_we_q) begin
                     if (sel == PORT_D) dbus_input_q <= bus.mem_rdata;
                     else               ibus_input_q <= bus.mem_rdata;
                  end
                  state <= RESP;
               end else if (wdog_expired) begin
                  mem_req_q   <= 1'b0;
                  if (!mem_we_q) begin
                     if (sel == PORT_D) dbus_input_q <= '0;
                     else               ibus_input_q <= '0;
                  end
                  bus_error_q <= 1'b1;
                  err_addr_q  <= mem_addr_q;
                  state       <= RESP;
               end
            end

            RESP: begin
               if (still_req) begin
                  if (sel == PORT_D) dbus_done_q <= 1'b1;
                  else               ibus_done_q <= 1'b1;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Drive the interface from the registered state.
   always_comb begin
      bus.ibus_input = ibus_input_q;
      bus.ibus_done  = ibus_done_q;
      bus.dbus_input = dbus_input_q;
      bus.dbus_done  = dbus_done_q;
      bus.mem_req    = mem_req_q;
      bus.mem_we     = mem_we_q;
      bus.mem_addr   = mem_addr_q;
      bus.mem_wdata  = mem_wdata_q;
      bus.bus_error  = bus_error_q;
      bus.err_addr   = err_addr_q;
   end

endmodule
